// File: rtl/handshake_constant_seq_pkg.sv
// Shared types and helpers for the handshaked constant sequencer.
package handshake_constant_seq_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } seq_state_t;

   // Pointer width is never zero, so a single-entry table still has a 1-bit pointer.
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/handshake_out_reg.sv
// Output payload register with valid/ready; exposes can_load to the producer.
module handshake_out_reg
   import handshake_constant_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_ready,
   output logic             o_can_load,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;

   always_comb begin
      o_can_load = !r_valid || i_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (o_can_load) begin
         r_valid <= i_load;
         if (i_load) begin
            r_data <= i_data;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/handshake_constant_seq.sv
// Handshaked constant source: each ctrl token emits a BURST_LEN-word walk through TABLE.
module handshake_constant_seq
   import handshake_constant_seq_pkg::*;
#(
   parameter int unsigned                    DATA_WIDTH = 17,
   parameter int unsigned                    DEPTH      = 4,
   parameter int unsigned                    BURST_LEN  = 1,
   parameter int unsigned                    WRAP       = 1,
   parameter logic [DEPTH*DATA_WIDTH-1:0]    TABLE      = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ctrl_valid,
   output logic                  ctrl_ready,
   output logic [DATA_WIDTH-1:0] outs,
   output logic                  outs_valid,
   input  logic                  outs_ready,
   output logic                  outs_last
);

   localparam int unsigned PW = ptr_width(DEPTH);
   localparam int unsigned BW = $clog2(BURST_LEN + 1);
   localparam logic [PW-1:0] PTR_MAX   = PW'(DEPTH - 1);
   localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);

   function automatic logic [DATA_WIDTH-1:0] table_entry(input logic [PW-1:0] idx);
      return TABLE[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
   endfunction

   seq_state_t             r_state;
   logic [PW-1:0]          r_ptr;
   logic [BW-1:0]          r_beat;

   logic                   w_can_load;
   logic                   w_accept;
   logic                   w_load;
   logic                   w_last;
   logic [PW-1:0]          w_ptr_next;
   logic [DATA_WIDTH:0]    w_payload_in;
   logic [DATA_WIDTH:0]    w_payload_out;

   // ctrl_ready is derived from state and downstream space only, never from ctrl_valid.
   always_comb begin
      ctrl_ready = !rst && (r_state == ST_IDLE) && w_can_load;
      w_accept   = ctrl_valid && ctrl_ready;
      w_load     = w_accept || ((r_state == ST_EMIT) && w_can_load);
   end

   always_comb begin
      w_last = 1'b0;
      if (r_state == ST_IDLE) begin
         w_last = (BURST_LEN == 1);
      end else begin
         w_last = (r_beat == BEAT_LAST);
      end
   end

   // WRAP=0 saturates at the final entry; with DEPTH=1 both modes pin the pointer at 0.
   always_comb begin
      w_ptr_next = r_ptr;
      if (r_ptr == PTR_MAX) begin
         w_ptr_next = (WRAP != 0) ? '0 : PTR_MAX;
      end else begin
         w_ptr_next = r_ptr + PW'(1);
      end
   end

   always_comb begin
      w_payload_in = {w_last, table_entry(r_ptr)};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_beat  <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_ptr  <= w_ptr_next;
                  r_beat <= BW'(1);
                  if (BURST_LEN > 1) begin
                     r_state <= ST_EMIT;
                  end
               end
            end
            ST_EMIT: begin
               if (w_can_load) begin
                  r_ptr  <= w_ptr_next;
                  r_beat <= r_beat + BW'(1);
                  if (r_beat == BEAT_LAST) begin
                     r_state <= ST_IDLE;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   handshake_out_reg #(
      .WIDTH (DATA_WIDTH + 1)
   ) u_out_reg (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_data     (w_payload_in),
      .i_ready    (outs_ready),
      .o_can_load (w_can_load),
      .o_valid    (outs_valid),
      .o_data     (w_payload_out)
   );

   assign outs      = w_payload_out[DATA_WIDTH-1:0];
   assign outs_last = w_payload_out[DATA_WIDTH];

endmodule

// File: tb/tb_handshake_constant_seq.sv
// Four sequencer configurations checked every cycle against a word-index model, plus literal walks.
module tb_handshake_constant_seq;

   localparam int NI = 4;
   localparam int unsigned BL_TAB [NI] = '{1, 3, 1, 2};
   localparam int unsigned WR_TAB [NI] = '{1, 1, 0, 1};
   localparam logic [16:0] ENT [4] = '{17'h1F0C3, 17'h00001, 17'h0ABCD, 17'h1FFFF};
   localparam logic [67:0] TBL = {17'h1FFFF, 17'h0ABCD, 17'h00001, 17'h1F0C3};

   logic        clk = 1'b0;
   logic        rs   [NI];
   logic        cv   [NI];
   logic        ordy [NI];
   logic        crdy [NI];
   logic        ov   [NI];
   logic        ol   [NI];
   logic [16:0] od   [NI];

   int n_checks = 0;
   int n_fail   = 0;

   int unsigned nextw  [NI];
   int unsigned popped [NI];
   logic        armed  [NI];
   logic        after_rst [NI];
   logic [17:0] obs0 [$];
   logic [17:0] obs1 [$];
   logic [17:0] obs2 [$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      handshake_constant_seq #(
         .DATA_WIDTH (17),
         .DEPTH      (4),
         .BURST_LEN  (BL_TAB[g]),
         .WRAP       (WR_TAB[g]),
         .TABLE      (TBL)
      ) u_dut (
         .clk        (clk),
         .rst        (rs[g]),
         .ctrl_valid (cv[g]),
         .ctrl_ready (crdy[g]),
         .outs       (od[g]),
         .outs_valid (ov[g]),
         .outs_ready (ordy[g]),
         .outs_last  (ol[g])
      );
   end

   task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d] at %0t: got %h expected %h", name, inst, $time, act, exp);
      end
   endtask

   // Word w of the global walk: table index from plain modulo / clamp arithmetic.
   function automatic logic [16:0] exp_word(input int inst, input int unsigned w);
      int unsigned idx;
      idx = (WR_TAB[inst] != 0) ? (w % 4) : ((w > 3) ? 3 : w);
      return ENT[idx];
   endfunction

   always @(negedge clk) begin : compare
      int unsigned sz;
      logic exp_v;
      logic exp_r;
      for (int i = 0; i < NI; i++) begin
         sz    = nextw[i] - popped[i];
         exp_v = (sz > 0);
         exp_r = !rs[i] && (sz <= 1) && ((sz == 0) || ordy[i]);
         if (armed[i]) begin
            check("ctrl_ready", i, 32'(crdy[i]), 32'(exp_r));
            check("outs_valid", i, 32'(ov[i]), 32'(exp_v));
            if (exp_v) begin
               check("outs", i, 32'(od[i]), 32'(exp_word(i, popped[i])));
               check("outs_last", i, 32'(ol[i]), 32'((popped[i] % BL_TAB[i]) == BL_TAB[i] - 1));
            end else if (after_rst[i]) begin
               check("rst_outs", i, 32'(od[i]), 32'h0);
               check("rst_last", i, 32'(ol[i]), 32'h0);
            end
         end
         after_rst[i] = rs[i];
         if (rs[i]) begin
            armed[i]  = 1'b1;
            nextw[i]  = 0;
            popped[i] = 0;
         end else if (armed[i]) begin
            if (exp_v && ordy[i]) begin
               case (i)
                  0: obs0.push_back({ol[i], od[i]});
                  1: obs1.push_back({ol[i], od[i]});
                  2: obs2.push_back({ol[i], od[i]});
                  default: ;
               endcase
               popped[i]++;
            end
            if (cv[i] && crdy[i]) begin
               nextw[i] += BL_TAB[i];
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [17:0] EXP0 [6] = '{
      {1'b1, 17'h1F0C3}, {1'b1, 17'h00001}, {1'b1, 17'h0ABCD},
      {1'b1, 17'h1FFFF}, {1'b1, 17'h1F0C3}, {1'b1, 17'h00001}};
   localparam logic [17:0] EXP2 [6] = '{
      {1'b1, 17'h1F0C3}, {1'b1, 17'h00001}, {1'b1, 17'h0ABCD},
      {1'b1, 17'h1FFFF}, {1'b1, 17'h1FFFF}, {1'b1, 17'h1FFFF}};
   localparam logic [17:0] EXP1 [10] = '{
      {1'b0, 17'h1F0C3}, {1'b0, 17'h00001}, {1'b1, 17'h0ABCD},
      {1'b0, 17'h1F0C3}, {1'b0, 17'h00001}, {1'b1, 17'h0ABCD},
      {1'b0, 17'h1F0C3},
      {1'b0, 17'h1F0C3}, {1'b0, 17'h00001}, {1'b1, 17'h0ABCD}};

   initial begin
      for (int i = 0; i < NI; i++) begin
         rs[i] = 1'b1; cv[i] = 1'b0; ordy[i] = 1'b0;
         nextw[i] = 0; popped[i] = 0; armed[i] = 1'b0; after_rst[i] = 1'b0;
      end
      repeat (3) tick();
      for (int i = 0; i < NI; i++) rs[i] = 1'b0;

      // Back-to-back single-word tokens, wrapping (inst 0) and saturating (inst 2).
      cv[0] = 1'b1; ordy[0] = 1'b1; cv[2] = 1'b1; ordy[2] = 1'b1;
      repeat (6) tick();
      cv[0] = 1'b0; cv[2] = 1'b0;
      repeat (3) tick();
      ordy[0] = 1'b0; ordy[2] = 1'b0;

      // Three-word burst: ctrl_ready low for two cycles after the accept.
      cv[1] = 1'b1; ordy[1] = 1'b1;
      tick();
      cv[1] = 1'b0;
      @(negedge clk); check("b3_busy0", 1, 32'(crdy[1]), 32'h0);
      tick();
      @(negedge clk); check("b3_busy1", 1, 32'(crdy[1]), 32'h0);
      tick();
      @(negedge clk); check("b3_idle", 1, 32'(crdy[1]), 32'h1);
      repeat (2) tick();
      rs[1] = 1'b1; tick(); rs[1] = 1'b0;

      // Stall on word 2 for four cycles.
      cv[1] = 1'b1; tick();
      cv[1] = 1'b0; tick();
      ordy[1] = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("stall_outs", 1, 32'(od[1]), 32'h00001);
         check("stall_valid", 1, 32'(ov[1]), 32'h1);
         tick();
      end
      ordy[1] = 1'b1;
      repeat (3) tick();
      rs[1] = 1'b1; tick(); rs[1] = 1'b0;

      // Reset while word 2 of a burst is valid.
      cv[1] = 1'b1; ordy[1] = 1'b1; tick();
      cv[1] = 1'b0; tick();
      rs[1] = 1'b1; ordy[1] = 1'b0;
      @(negedge clk);
      check("pre_rst_outs", 1, 32'(od[1]), 32'h00001);
      tick();
      rs[1] = 1'b0;
      @(negedge clk);
      check("post_rst_valid", 1, 32'(ov[1]), 32'h0);
      check("post_rst_outs", 1, 32'(od[1]), 32'h0);
      cv[1] = 1'b1; tick();
      cv[1] = 1'b0;
      @(negedge clk);
      check("restart_outs", 1, 32'(od[1]), 32'h1F0C3);
      check("restart_valid", 1, 32'(ov[1]), 32'h1);
      ordy[1] = 1'b1;
      repeat (4) tick();
      ordy[1] = 1'b0;

      // Random traffic on all configurations with occasional resets.
      repeat (1000) begin
         for (int i = 0; i < NI; i++) begin
            cv[i]   = 1'($urandom_range(0, 1));
            ordy[i] = 1'($urandom_range(0, 1));
            rs[i]   = ($urandom_range(0, 99) == 0);
         end
         tick();
      end
      for (int i = 0; i < NI; i++) begin
         rs[i] = 1'b0; cv[i] = 1'b0; ordy[i] = 1'b0;
      end
      repeat (2) tick();

      check("obs0_len", 0, 32'(obs0.size() >= 6), 32'h1);
      for (int k = 0; k < 6; k++)
         if (k < obs0.size()) check("walk_wrap", 0, 32'(obs0[k]), 32'(EXP0[k]));
      check("obs2_len", 2, 32'(obs2.size() >= 6), 32'h1);
      for (int k = 0; k < 6; k++)
         if (k < obs2.size()) check("walk_sat", 2, 32'(obs2[k]), 32'(EXP2[k]));
      check("obs1_len", 1, 32'(obs1.size() >= 10), 32'h1);
      for (int k = 0; k < 10; k++)
         if (k < obs1.size()) check("walk_burst", 1, 32'(obs1[k]), 32'(EXP1[k]));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
